// File: rtl/ascon_aead128_arbiter.sv
// Round-robin arbiter that shares one ascon_aead128 core between n_ch requester streams.
// Input grants last for a whole message; an id FIFO routes output beats back in grant order.
module ascon_aead128_arbiter #(
  parameter int unsigned n_ch     = 2,
  parameter int unsigned l2_bw    = 3,
  parameter int unsigned l2_depth = 2,
  localparam int unsigned kw      = 128 / (1 << l2_bw)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [n_ch-1:0]       s_valid,
  output logic [n_ch-1:0]       s_ready,
  input  logic [n_ch-1:0]       s_last,
  input  logic [n_ch-1:0]       s_enc_decn,
  input  logic [128*n_ch-1:0]   s_data,
  input  logic [kw*n_ch-1:0]    s_keep,
  input  logic [128*n_ch-1:0]   s_key,
  input  logic [128*n_ch-1:0]   s_nonce,
  input  logic [n_ch-1:0]       s_ad,
  input  logic [n_ch-1:0]       s_p,
  output logic                  c_s_valid,
  output logic                  c_s_last,
  output logic                  c_s_enc_decn,
  output logic [127:0]          c_s_data,
  output logic [kw-1:0]         c_s_keep,
  output logic [127:0]          c_s_key,
  output logic [127:0]          c_s_nonce,
  output logic                  c_s_ad,
  output logic                  c_s_p,
  input  logic                  c_s_ready,
  input  logic                  c_m_valid,
  input  logic                  c_m_last,
  input  logic                  c_m_enc_decn,
  input  logic [127:0]          c_m_data,
  input  logic [kw-1:0]         c_m_keep,
  input  logic                  c_m_ad,
  input  logic                  c_m_p,
  input  logic                  c_m_t,
  output logic                  c_m_ready,
  output logic [n_ch-1:0]       m_valid,
  input  logic [n_ch-1:0]       m_ready,
  output logic [n_ch-1:0]       m_last,
  output logic [n_ch-1:0]       m_enc_decn,
  output logic [n_ch-1:0]       m_ad,
  output logic [n_ch-1:0]       m_p,
  output logic [n_ch-1:0]       m_t,
  output logic [128*n_ch-1:0]   m_data,
  output logic [kw*n_ch-1:0]    m_keep,
  output logic [l2_depth:0]     inflight
);

  localparam int unsigned Depth = 1 << l2_depth;
  localparam int unsigned IdW   = (n_ch > 1) ? $clog2(n_ch) : 1;

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e              state_q;
  logic [IdW-1:0]      grant_q;
  logic [IdW-1:0]      rr_q;
  logic [IdW-1:0]      fifo_q [Depth];
  logic [l2_depth-1:0] wptr_q;
  logic [l2_depth-1:0] rptr_q;
  logic [l2_depth:0]   count_q;

  logic                pick_found;
  logic [IdW-1:0]      pick_id;
  logic [IdW-1:0]      cand;
  logic [IdW-1:0]      head;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                release_lock;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < n_ch; i++) begin
      cand = IdW'((32'(rr_q) + i) % n_ch);
      if (!pick_found && s_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    c_s_valid    = 1'b0;
    s_ready      = '0;
    c_s_last     = 1'b0;
    c_s_enc_decn = 1'b0;
    c_s_data     = '0;
    c_s_keep     = '0;
    c_s_key      = '0;
    c_s_nonce    = '0;
    c_s_ad       = 1'b0;
    c_s_p        = 1'b0;
    for (int unsigned i = 0; i < n_ch; i++) begin
      if (grant_q == IdW'(i)) begin
        c_s_last     = s_last[i];
        c_s_enc_decn = s_enc_decn[i];
        c_s_data     = s_data[128*i +: 128];
        c_s_keep     = s_keep[kw*i +: kw];
        c_s_key      = s_key[128*i +: 128];
        c_s_nonce    = s_nonce[128*i +: 128];
        c_s_ad       = s_ad[i];
        c_s_p        = s_p[i];
        if (state_q == StLock) begin
          c_s_valid  = s_valid[i];
          s_ready[i] = c_s_ready;
        end
      end
    end
  end

  assign head       = fifo_q[rptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (l2_depth+1)'(Depth));

  always_comb begin
    c_m_ready = 1'b0;
    m_valid   = '0;
    if (!fifo_empty) begin
      c_m_ready     = m_ready[head];
      m_valid[head] = c_m_valid;
    end
  end

  assign pop          = c_m_valid & c_m_ready & c_m_t & c_m_last;
  // A full FIFO still accepts a grant when the head tag leaves in the same cycle.
  assign push         = (state_q == StIdle) && pick_found && (!fifo_full || pop);
  assign release_lock = c_s_valid & c_s_ready & c_s_p & c_s_last;

  assign m_last     = {n_ch{c_m_last}};
  assign m_enc_decn = {n_ch{c_m_enc_decn}};
  assign m_ad       = {n_ch{c_m_ad}};
  assign m_p        = {n_ch{c_m_p}};
  assign m_t        = {n_ch{c_m_t}};
  assign m_data     = {n_ch{c_m_data}};
  assign m_keep     = {n_ch{c_m_keep}};
  assign inflight   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (push) begin
            grant_q <= pick_id;
            state_q <= StLock;
          end
        end
        StLock: begin
          if (release_lock) begin
            state_q <= StIdle;
            rr_q    <= (grant_q == IdW'(n_ch - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      endcase
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= pick_id;
  end

  a_hold_valid: assert property (@(posedge clk) disable iff (rst)
    (state_q == StLock && c_s_valid && !c_s_ready) |=> c_s_valid);

  a_no_orphan_out: assert property (@(posedge clk) disable iff (rst)
    c_m_valid |-> !fifo_empty);

endmodule

// File: tb/tb_ascon_aead128_arbiter.sv
// Directed and randomised checks of the two-channel ascon arbiter; the bench plays the core.
module tb_ascon_aead128_arbiter;

  localparam int unsigned NCh = 2;
  localparam int unsigned Kw  = 16;

  typedef struct {
    int ch;
    int sq;
  } msg_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCh-1:0]       s_valid, s_ready, s_last, s_enc_decn, s_ad, s_p;
  logic [128*NCh-1:0]   s_data, s_key, s_nonce;
  logic [Kw*NCh-1:0]    s_keep;
  logic                 c_s_valid, c_s_last, c_s_enc_decn, c_s_ad, c_s_p, c_s_ready;
  logic [127:0]         c_s_data, c_s_key, c_s_nonce;
  logic [Kw-1:0]        c_s_keep;
  logic                 c_m_valid, c_m_last, c_m_enc_decn, c_m_ad, c_m_p, c_m_t, c_m_ready;
  logic [127:0]         c_m_data;
  logic [Kw-1:0]        c_m_keep;
  logic [NCh-1:0]       m_valid, m_ready, m_last, m_enc_decn, m_ad, m_p, m_t;
  logic [128*NCh-1:0]   m_data;
  logic [Kw*NCh-1:0]    m_keep;
  logic [2:0]           inflight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_aead128_arbiter #(.n_ch(NCh), .l2_bw(3), .l2_depth(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_enc_decn(s_enc_decn),
    .s_data(s_data), .s_keep(s_keep), .s_key(s_key), .s_nonce(s_nonce),
    .s_ad(s_ad), .s_p(s_p),
    .c_s_valid(c_s_valid), .c_s_last(c_s_last), .c_s_enc_decn(c_s_enc_decn),
    .c_s_data(c_s_data), .c_s_keep(c_s_keep), .c_s_key(c_s_key), .c_s_nonce(c_s_nonce),
    .c_s_ad(c_s_ad), .c_s_p(c_s_p), .c_s_ready(c_s_ready),
    .c_m_valid(c_m_valid), .c_m_last(c_m_last), .c_m_enc_decn(c_m_enc_decn),
    .c_m_data(c_m_data), .c_m_keep(c_m_keep), .c_m_ad(c_m_ad), .c_m_p(c_m_p),
    .c_m_t(c_m_t), .c_m_ready(c_m_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_enc_decn(m_enc_decn),
    .m_ad(m_ad), .m_p(m_p), .m_t(m_t), .m_data(m_data), .m_keep(m_keep),
    .inflight(inflight)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [127:0] mkdata(input int ch, input int sq, input int b);
    return {80'h0, ch[15:0], sq[15:0], b[15:0]};
  endfunction

  task automatic clear_inputs();
    s_valid = '0; s_last = '0; s_enc_decn = '0; s_ad = '0; s_p = '0;
    s_data = '0; s_key = '0; s_nonce = '0; s_keep = '0;
    c_s_ready = 1'b0;
    c_m_valid = 1'b0; c_m_last = 1'b0; c_m_enc_decn = 1'b0; c_m_ad = 1'b0;
    c_m_p = 1'b0; c_m_t = 1'b0; c_m_data = '0; c_m_keep = '0;
    m_ready = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_beat(input int ch, input logic ad, input logic p, input logic last,
                          input logic [127:0] d);
    s_valid[ch] = 1'b1;
    s_ad[ch]    = ad;
    s_p[ch]     = p;
    s_last[ch]  = last;
    s_data[128*ch +: 128] = d;
    s_keep[Kw*ch +: Kw]   = p ? 16'hffff : 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_ready = 2'b11;
    tick();
    tick();
    settle();
    checks++;
    if (s_ready !== 2'b00) begin
      errors++; $display("FAIL reset_s_ready got %b exp 00", s_ready);
    end
    checks++;
    if (c_s_valid !== 1'b0) begin
      errors++; $display("FAIL reset_c_s_valid got %b exp 0", c_s_valid);
    end
    checks++;
    if (m_valid !== 2'b00 || c_m_ready !== 1'b0) begin
      errors++; $display("FAIL reset_out got m_valid=%b c_m_ready=%b exp 00/0", m_valid, c_m_ready);
    end
    checks++;
    if (inflight !== 3'd0) begin
      errors++; $display("FAIL reset_inflight got %0d exp 0", inflight);
    end
    tick();
    rst = 1'b0;
    m_ready = '0;
  endtask

  task automatic test_single_channel();
    c_s_ready = 1'b1;
    s_enc_decn[0] = 1'b1;
    s_key[127:0] = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    set_beat(0, 1'b1, 1'b0, 1'b1, 128'h11);
    settle();
    checks++;
    if ({c_s_valid, s_ready} !== 3'b000) begin
      errors++; $display("FAIL single_bubble got %b exp 000", {c_s_valid, s_ready});
    end
    tick();
    settle();
    checks++;
    if (c_s_valid !== 1'b1 || c_s_ad !== 1'b1 || c_s_data !== 128'h11 || s_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ad_beat got v=%b ad=%b data=%h rdy=%b exp 1/1/11/01",
               c_s_valid, c_s_ad, c_s_data, s_ready);
    end
    checks++;
    if (c_s_key !== 128'h0123_4567_89ab_cdef_0011_2233_4455_6677 || c_s_enc_decn !== 1'b1) begin
      errors++; $display("FAIL single_key got %h/%b exp key/1", c_s_key, c_s_enc_decn);
    end
    checks++;
    if (inflight !== 3'd1) begin
      errors++; $display("FAIL single_inflight1 got %0d exp 1", inflight);
    end
    tick();
    set_beat(0, 1'b0, 1'b1, 1'b0, 128'h22);
    settle();
    checks++;
    if (s_ready !== 2'b01 || c_s_data !== 128'h22 || c_s_p !== 1'b1) begin
      errors++; $display("FAIL single_ad_last_holds got rdy=%b data=%h exp 01/22", s_ready, c_s_data);
    end
    tick();
    set_beat(0, 1'b0, 1'b1, 1'b1, 128'h33);
    settle();
    checks++;
    if (c_s_last !== 1'b1 || c_s_data !== 128'h33) begin
      errors++; $display("FAIL single_p_last got last=%b data=%h exp 1/33", c_s_last, c_s_data);
    end
    tick();
    s_valid = '0;
    c_m_valid = 1'b1; c_m_t = 1'b1; c_m_last = 1'b1; c_m_data = 128'h44;
    m_ready = 2'b01;
    settle();
    checks++;
    if (s_ready !== 2'b00 || c_s_valid !== 1'b0 || inflight !== 3'd1) begin
      errors++;
      $display("FAIL single_released got rdy=%b v=%b inflight=%0d exp 00/0/1",
               s_ready, c_s_valid, inflight);
    end
    checks++;
    if (m_valid !== 2'b01 || c_m_ready !== 1'b1) begin
      errors++; $display("FAIL single_route got m_valid=%b c_m_ready=%b exp 01/1", m_valid, c_m_ready);
    end
    checks++;
    if (m_data !== {2{128'h44}} || m_t !== 2'b11) begin
      errors++; $display("FAIL single_broadcast got %h t=%b", m_data, m_t);
    end
    tick();
    c_m_valid = 1'b0;
    settle();
    checks++;
    if (inflight !== 3'd0) begin
      errors++; $display("FAIL single_inflight0 got %0d exp 0", inflight);
    end
  endtask

  task automatic test_two_channels();
    apply_reset();
    c_s_ready = 1'b1;
    set_beat(0, 1'b0, 1'b1, 1'b1, 128'ha0);
    set_beat(1, 1'b0, 1'b1, 1'b1, 128'hb1);
    tick();
    settle();
    checks++;
    if (s_ready !== 2'b01 || c_s_data !== 128'ha0) begin
      errors++; $display("FAIL two_first_grant got rdy=%b data=%h exp 01/a0", s_ready, c_s_data);
    end
    tick();
    s_valid[0] = 1'b0;
    settle();
    checks++;
    if (s_ready !== 2'b00 || c_s_valid !== 1'b0) begin
      errors++; $display("FAIL two_bubble got rdy=%b v=%b exp 00/0", s_ready, c_s_valid);
    end
    tick();
    settle();
    checks++;
    if (s_ready !== 2'b10 || c_s_data !== 128'hb1) begin
      errors++; $display("FAIL two_second_grant got rdy=%b data=%h exp 10/b1", s_ready, c_s_data);
    end
    tick();
    s_valid[1] = 1'b0;
    c_m_valid = 1'b1; c_m_t = 1'b1; c_m_last = 1'b1;
    m_ready = 2'b11;
    settle();
    checks++;
    if (inflight !== 3'd2 || m_valid !== 2'b01) begin
      errors++; $display("FAIL two_tag0 got inflight=%0d m_valid=%b exp 2/01", inflight, m_valid);
    end
    tick();
    settle();
    checks++;
    if (inflight !== 3'd1 || m_valid !== 2'b10) begin
      errors++; $display("FAIL two_tag1 got inflight=%0d m_valid=%b exp 1/10", inflight, m_valid);
    end
    tick();
    c_m_valid = 1'b0;
    settle();
    checks++;
    if (inflight !== 3'd0 || m_valid !== 2'b00) begin
      errors++; $display("FAIL two_drained got inflight=%0d m_valid=%b exp 0/00", inflight, m_valid);
    end
  endtask

  task automatic test_depth_full();
    apply_reset();
    c_s_ready = 1'b1;
    set_beat(0, 1'b0, 1'b1, 1'b1, 128'hc0);
    repeat (8) tick();
    c_m_valid = 1'b1; c_m_t = 1'b1; c_m_last = 1'b1;
    m_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (s_ready !== 2'b00 || c_s_valid !== 1'b0 || c_m_ready !== 1'b0) begin
        errors++;
        $display("FAIL depth_blocked[%0d] got rdy=%b v=%b c_m_ready=%b exp 00/0/0",
                 i, s_ready, c_s_valid, c_m_ready);
      end
      tick();
    end
    settle();
    checks++;
    if (inflight !== 3'd4) begin
      errors++; $display("FAIL depth_inflight got %0d exp 4", inflight);
    end
  endtask

  task automatic test_push_pop_full();
    tick();
    m_ready = 2'b01;
    settle();
    checks++;
    if (c_m_ready !== 1'b1 || m_valid !== 2'b01) begin
      errors++; $display("FAIL pp_route got c_m_ready=%b m_valid=%b exp 1/01", c_m_ready, m_valid);
    end
    tick();
    c_m_valid = 1'b0;
    settle();
    checks++;
    if (inflight !== 3'd4 || s_ready !== 2'b01) begin
      errors++; $display("FAIL pp_grant got inflight=%0d rdy=%b exp 4/01", inflight, s_ready);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    c_s_ready = 1'b1;
    set_beat(0, 1'b0, 1'b1, 1'b1, 128'hd0);
    tick();
    tick();
    s_valid[0] = 1'b0;
    set_beat(1, 1'b1, 1'b0, 1'b0, 128'hd1);
    tick();
    tick();
    settle();
    checks++;
    if (s_ready !== 2'b10 || inflight !== 3'd2) begin
      errors++; $display("FAIL mid_locked got rdy=%b inflight=%0d exp 10/2", s_ready, inflight);
    end
    rst = 1'b1;
    m_ready = 2'b11;
    tick();
    settle();
    checks++;
    if (s_ready !== 2'b00 || c_s_valid !== 1'b0 || m_valid !== 2'b00 || c_m_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_outputs got rdy=%b v=%b m_valid=%b c_m_ready=%b exp all 0",
               s_ready, c_s_valid, m_valid, c_m_ready);
    end
    checks++;
    if (inflight !== 3'd0) begin
      errors++; $display("FAIL mid_inflight got %0d exp 0", inflight);
    end
    rst = 1'b0;
    set_beat(0, 1'b0, 1'b1, 1'b1, 128'he0);
    tick();
    settle();
    checks++;
    if (s_ready !== 2'b01 || c_s_data !== 128'he0) begin
      errors++; $display("FAIL mid_rr_zero got rdy=%b data=%h exp 01/e0", s_ready, c_s_data);
    end
  endtask

  task automatic test_random();
    int beat[NCh], nad[NCh], np[NCh], cseq[NCh], issued[NCh], delivered[NCh];
    bit active[NCh], in_hs[NCh];
    msg_t core_q[$];
    int started, done, out_beat, nh, hch, cyc;
    bit m_hs;
    logic [127:0] exp_data;
    logic [NCh-1:0] exp_mv;
    logic exp_p, exp_last;
    apply_reset();
    for (int ch = 0; ch < NCh; ch++) begin
      beat[ch] = 0; nad[ch] = 0; np[ch] = 1; cseq[ch] = 0;
      issued[ch] = 0; delivered[ch] = 0; active[ch] = 0; in_hs[ch] = 0;
    end
    started = 0; done = 0; out_beat = 0; cyc = 0; m_hs = 0;
    while (done < 200 && cyc < 20000) begin
      for (int ch = 0; ch < NCh; ch++) begin
        if (in_hs[ch]) s_valid[ch] = 1'b0;
        in_hs[ch] = 0;
        if (!active[ch] && started < 200) begin
          active[ch] = 1; nad[ch] = $urandom_range(0, 1); np[ch] = $urandom_range(1, 2);
          beat[ch] = 0; cseq[ch] = issued[ch]; issued[ch]++; started++;
        end
        if (active[ch] && !s_valid[ch] && $urandom_range(0, 3) != 0) s_valid[ch] = 1'b1;
        if (active[ch]) begin
          s_ad[ch]   = beat[ch] < nad[ch];
          s_p[ch]    = beat[ch] >= nad[ch];
          s_last[ch] = (beat[ch] == nad[ch] - 1) || (beat[ch] == nad[ch] + np[ch] - 1);
          s_data[128*ch +: 128] = mkdata(ch, cseq[ch], beat[ch]);
        end
      end
      c_s_ready = ($urandom_range(0, 3) != 0);
      if (m_hs) c_m_valid = 1'b0;
      m_hs = 0;
      if (!c_m_valid && core_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        c_m_valid = 1'b1;
        c_m_last  = 1'b1;
        c_m_t     = (out_beat == 1);
        c_m_p     = (out_beat == 0);
        c_m_data  = mkdata(core_q[0].ch, core_q[0].sq, out_beat);
      end
      m_ready = NCh'($urandom);
      settle();
      nh = 0; hch = 0;
      for (int ch = 0; ch < NCh; ch++) begin
        if (s_valid[ch] && s_ready[ch]) begin
          nh++; hch = ch;
        end
      end
      if (nh != 0 || (c_s_valid && c_s_ready)) begin
        exp_data = mkdata(hch, cseq[hch], beat[hch]);
        exp_p    = beat[hch] >= nad[hch];
        exp_last = (beat[hch] == nad[hch] - 1) || (beat[hch] == nad[hch] + np[hch] - 1);
        checks++;
        if (nh != 1 || !(c_s_valid && c_s_ready) || c_s_data !== exp_data ||
            c_s_p !== exp_p || c_s_last !== exp_last) begin
          errors++;
          $display("FAIL rand_in_beat cyc %0d got nh=%0d data=%h p=%b last=%b exp 1/%h/%b/%b",
                   cyc, nh, c_s_data, c_s_p, c_s_last, exp_data, exp_p, exp_last);
        end
        in_hs[hch] = 1;
        if (beat[hch] == nad[hch] + np[hch] - 1) begin
          core_q.push_back('{hch, cseq[hch]});
          active[hch] = 0;
        end else begin
          beat[hch]++;
        end
      end
      if (c_m_valid) begin
        exp_mv = '0;
        exp_mv[core_q[0].ch] = 1'b1;
        checks++;
        if (m_valid !== exp_mv || c_m_ready !== m_ready[core_q[0].ch]) begin
          errors++;
          $display("FAIL rand_route cyc %0d got m_valid=%b c_m_ready=%b exp %b/%b",
                   cyc, m_valid, c_m_ready, exp_mv, m_ready[core_q[0].ch]);
        end
        if (c_m_ready === 1'b1) begin
          m_hs = 1;
          if (out_beat == 1) begin
            delivered[core_q[0].ch]++;
            void'(core_q.pop_front());
            done++;
            out_beat = 0;
          end else begin
            out_beat = 1;
          end
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (done != 200) begin
      errors++; $display("FAIL rand_complete got %0d messages exp 200 within cycle budget", done);
    end
    for (int ch = 0; ch < NCh; ch++) begin
      checks++;
      if (delivered[ch] != issued[ch]) begin
        errors++;
        $display("FAIL rand_count ch%0d got %0d delivered exp %0d", ch, delivered[ch], issued[ch]);
      end
    end
    c_m_valid = 1'b0;
    s_valid = '0;
    settle();
    checks++;
    if (inflight !== 3'd0) begin
      errors++; $display("FAIL rand_inflight got %0d exp 0", inflight);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_channel();
    test_two_channels();
    test_depth_full();
    test_push_pop_full();
    test_mid_reset();
    test_random();
    apply_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
